// File: rtl/multi_channel_arbiter_if.sv
// Request/response bundle between the pipeline end stages, the arbiter and shared_resource.
// master = requesting side (pipelines + shared_resource ready); slave = the arbiter.
interface multi_channel_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int ID_W   = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH*ADDR_W-1:0] in_address;
  logic [NUM_CH*ID_W-1:0]   in_id;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        out_stall;
  logic                     in_ready;
  logic [ADDR_W-1:0]        out_address;
  logic [ID_W-1:0]          out_id;
  logic [CH_W-1:0]          out_choice;
  logic                     out_valid;

  modport master (
    output in_address, in_id, in_valid, in_ready,
    input  out_stall, out_address, out_id, out_choice, out_valid
  );

  modport slave (
    input  in_address, in_id, in_valid, in_ready,
    output out_stall, out_address, out_id, out_choice, out_valid
  );
endinterface

// File: rtl/multi_channel_arbiter.sv
// NUM_CH-way round-robin arbiter feeding a one-entry output register onto shared_resource.
// Optional per-channel saturating grant counters under MULTI_CHANNEL_ARBITER_STATS_EN.
module multi_channel_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int ID_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  multi_channel_arbiter_if.slave   bus
`ifdef MULTI_CHANNEL_ARBITER_STATS_EN
  ,
  input  logic                     clear_stats,
  output logic [NUM_CH*16-1:0]     out_grant_count
`endif
);
  localparam int CH_W = $clog2(NUM_CH);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [ID_W-1:0]   r_id;
  logic [CH_W-1:0]   r_choice;
  logic [CH_W-1:0]   r_rr_ptr;

  logic              w_any;
  logic              w_fire;
  logic              w_can_load;
  logic [CH_W-1:0]   w_g;
  logic [CH_W:0]     w_idx;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [NUM_CH-1:0] w_stall;

  // Rotating priority search starting at r_rr_ptr; extra index bit absorbs the wrap.
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (CH_W+1)'(k);
      if (w_idx >= (CH_W+1)'(NUM_CH))
        w_idx = w_idx - (CH_W+1)'(NUM_CH);
      if (!w_any && bus.in_valid[w_idx[CH_W-1:0]]) begin
        w_any = 1'b1;
        w_g   = w_idx[CH_W-1:0];
      end
    end
  end

  assign w_can_load = !r_valid || bus.in_ready;
  assign w_fire     = w_can_load && w_any && reset;
  assign w_ptr_nxt  = (w_g == CH_W'(NUM_CH-1)) ? '0 : w_g + CH_W'(1);

  always_comb begin
    w_stall = bus.in_valid;
    for (int c = 0; c < NUM_CH; c++)
      if (w_fire && w_g == CH_W'(c)) w_stall[c] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_addr   <= '0;
      r_id     <= '0;
      r_choice <= '0;
      r_rr_ptr <= '0;
    end else if (w_fire) begin
      r_valid  <= 1'b1;
      r_addr   <= bus.in_address[w_g*ADDR_W +: ADDR_W];
      r_id     <= bus.in_id[w_g*ID_W +: ID_W];
      r_choice <= w_g;
      r_rr_ptr <= w_ptr_nxt;
    end else if (r_valid && bus.in_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.out_stall   = w_stall;
  assign bus.out_valid   = r_valid;
  assign bus.out_address = r_addr;
  assign bus.out_id      = r_id;
  assign bus.out_choice  = r_choice;

`ifdef MULTI_CHANNEL_ARBITER_STATS_EN
  logic [NUM_CH-1:0][15:0] r_cnt;

  // Clear takes priority over a coincident grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear_stats) begin
      r_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (w_fire && w_g == CH_W'(c) && r_cnt[c] != 16'hFFFF)
          r_cnt[c] <= r_cnt[c] + 16'd1;
    end
  end

  assign out_grant_count = r_cnt;
`endif
endmodule

// File: tb/tb_multi_channel_arbiter.sv
// Directed bench for multi_channel_arbiter: transaction-level model checked every cycle
// plus literal expectations for the reset, rotation, wrap, hold and async-reset cases.
module tb_multi_channel_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multi_channel_arbiter_if #(.NUM_CH(N), .ADDR_W(AW), .ID_W(IW)) bus();

  logic [N-1:0][AW-1:0] t_addr;
  logic [N-1:0][IW-1:0] t_id;
  logic [N-1:0]         t_valid;
  logic                 t_ready;

  assign bus.in_address = t_addr;
  assign bus.in_id      = t_id;
  assign bus.in_valid   = t_valid;
  assign bus.in_ready   = t_ready;

`ifdef MULTI_CHANNEL_ARBITER_STATS_EN
  logic                 clear_stats;
  logic [N-1:0][15:0]   grant_count;

  multi_channel_arbiter #(.NUM_CH(N), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .clear_stats(clear_stats), .out_grant_count(grant_count)
  );
`else
  multi_channel_arbiter #(.NUM_CH(N), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
`endif

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: what the output register holds, and where the next search starts.
  bit           m_valid = 0;
  logic [AW-1:0] m_addr = '0;
  logic [IW-1:0] m_id   = '0;
  int           m_ch  = 0;
  int           m_ptr = 0;
  int           m_cnt [N];
  int           mg, mc;
  bit           many, mfire;
  logic [N-1:0] mes;

  always @(negedge clk) begin
    if (!reset) begin
      m_valid = 0; m_addr = '0; m_id = '0; m_ch = 0; m_ptr = 0;
      for (int c = 0; c < N; c++) m_cnt[c] = 0;
    end
    many = 0; mg = 0;
    for (int k = 0; k < N; k++) begin
      mc = (m_ptr + k) % N;
      if (!many && t_valid[mc]) begin many = 1; mg = mc; end
    end
    mfire = (!m_valid || t_ready) && many && reset;
    mes = t_valid;
    if (mfire) mes[mg] = 1'b0;

    chk("model_stall",   bus.out_stall,   mes);
    chk("model_valid",   bus.out_valid,   m_valid);
    chk("model_address", bus.out_address, m_addr);
    chk("model_id",      bus.out_id,      m_id);
    chk("model_choice",  bus.out_choice,  m_ch);
`ifdef MULTI_CHANNEL_ARBITER_STATS_EN
    for (int c = 0; c < N; c++) chk("model_count", grant_count[c], m_cnt[c]);
    if (reset) begin
      if (clear_stats) for (int c = 0; c < N; c++) m_cnt[c] = 0;
      else if (mfire && m_cnt[mg] < 16'hFFFF) m_cnt[mg]++;
    end
`endif
    if (reset) begin
      if (mfire) begin
        m_valid = 1; m_addr = t_addr[mg]; m_id = t_id[mg]; m_ch = mg;
        m_ptr = (mg + 1) % N;
      end else if (m_valid && t_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] vec_v [14] = '{4'b0011, 4'b0110, 4'b0110, 4'b1001, 4'b0000, 4'b1111, 4'b1111,
                               4'b0101, 4'b1010, 4'b0001, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
  logic         vec_r [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    t_valid = '0;
    t_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      t_addr[c] = AW'(8'h10 + c);
      t_id[c]   = IW'(c);
    end
`ifdef MULTI_CHANNEL_ARBITER_STATS_EN
    clear_stats = 1'b0;
`endif
    repeat (2) step();
    reset = 1'b1;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_stall", bus.out_stall, 4'b0000);
    repeat (3) step();
    chk("idle_valid", bus.out_valid, 1'b0);
    chk("idle_stall", bus.out_stall, 4'b0000);

    // All channels valid: one grant per cycle rotating 0,1,2,3,0,1.
    t_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_choice", bus.out_choice, i % 4);
      chk("rr_id",     bus.out_id,     i % 4);
    end
    t_valid = '0;
    step();
    chk("drain_valid", bus.out_valid, 1'b0);

    // Single ch2 request held while shared_resource is not ready.
    t_addr[2] = 8'hA5;
    t_valid   = 4'b0100;
    t_ready   = 1'b0;
    step();
    chk("ch2_valid",   bus.out_valid,   1'b1);
    chk("ch2_address", bus.out_address, 8'hA5);
    chk("ch2_choice",  bus.out_choice,  2);
    chk("ch2_stall",   bus.out_stall,   4'b0100);
    step();
    chk("ch2_hold_stall", bus.out_stall, 4'b0100);
    t_ready = 1'b1;
    #1;
    chk("ch2_release_stall", bus.out_stall, 4'b0000);
    step();
    chk("ch2_reload_choice", bus.out_choice, 2);
    t_valid = '0;
    step();

    // Grant ch3 wraps the pointer to 0, so ch1 beats ch3 next.
    t_valid = 4'b1000;
    step();
    chk("wrap_choice3", bus.out_choice, 3);
    t_valid = 4'b1010;
    #1;
    chk("wrap_stall", bus.out_stall, 4'b1000);
    step();
    chk("wrap_choice1", bus.out_choice, 1);
    step();
    chk("wrap_then3", bus.out_choice, 3);
    t_valid = '0;
    step();

    // Asynchronous reset with a request held.
    t_valid = 4'b1111;
    t_ready = 1'b0;
    step();
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_stall", bus.out_stall, 4'b1111);
    step();
    reset   = 1'b1;
    t_ready = 1'b1;
    step();
    chk("post_rst_choice", bus.out_choice, 0);
    chk("post_rst_valid",  bus.out_valid,  1'b1);

    // Directed vector table, checked by the model.
    for (int i = 0; i < 14; i++) begin
      for (int c = 0; c < N; c++) begin
        t_addr[c] = AW'(i * 16 + c);
        t_id[c]   = IW'(i + c);
      end
      t_valid = vec_v[i];
      t_ready = vec_r[i];
      step();
    end

`ifdef MULTI_CHANNEL_ARBITER_STATS_EN
    t_valid = 4'b0001;
    t_ready = 1'b1;
    repeat (70000) step();
    chk("stats_sat", grant_count[0], 16'hFFFF);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("stats_clear", grant_count[0], 16'h0000);
`endif

    t_valid = '0;
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
